// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the two-port character-ROM arbiter.
package rom_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/rom_arb_rsp_pipe.sv
// Two-stage valid/id pipeline that follows each ROM read and steers the
// captured word to the port that issued it.
module rom_arb_rsp_pipe
    import rom_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  req_id_t           issue_id,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              occupied
);

    logic              s1_valid_q, s1_valid_d;
    req_id_t           s1_id_q, s1_id_d;
    logic              s2_valid_q, s2_valid_d;
    req_id_t           s2_id_q, s2_id_d;
    logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;

    always_comb begin
        s1_valid_d  = issue_valid;
        s1_id_d     = issue_valid ? issue_id : 1'b0;
        s2_valid_d  = s1_valid_q;
        s2_id_d     = s1_valid_q ? s1_id_q : 1'b0;
        rsp0_data_d = rsp0_data_q;
        rsp1_data_d = rsp1_data_q;
        // ROM output belongs to the stage-1 read; only its owner's register updates
        if (s1_valid_q && (s1_id_q == 1'b0)) rsp0_data_d = mem_dout;
        if (s1_valid_q && (s1_id_q == 1'b1)) rsp1_data_d = mem_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= 1'b0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s2_valid_q  <= s2_valid_d;
            s2_id_q     <= s2_id_d;
            rsp0_data_q <= rsp0_data_d;
            rsp1_data_q <= rsp1_data_d;
        end
    end

    assign rsp0_valid = s2_valid_q && (s2_id_q == 1'b0);
    assign rsp1_valid = s2_valid_q && (s2_id_q == 1'b1);
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign occupied   = s1_valid_q || s2_valid_q;

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one combinational character ROM between two
// requesters; burst locking is built only when ROM_ARBITER_LOCK_EN is defined.
//
// state | meaning
// ARB   | round-robin between both requesters
// LOCK0 | requester 0 holds the ROM for a burst
// LOCK1 | requester 1 holds the ROM for a burst
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_lock,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_lock,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    req_id_t           last_q, last_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              lock0, lock1;
    logic              xfer0, xfer1;
    logic              pipe_occupied;

`ifdef ROM_ARBITER_LOCK_EN
    assign lock0 = req0_lock;
    assign lock1 = req1_lock;
`else
    logic unused_lock;
    assign unused_lock = req0_lock | req1_lock;
    assign lock0       = 1'b0;
    assign lock1       = 1'b0;
`endif

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        state_d    = state_q;
        case (state_q)
            ARB: begin
                req0_ready = req0_valid && (!req1_valid || (last_q == 1'b1));
                req1_ready = req1_valid && (!req0_valid || (last_q == 1'b0));
            end
            LOCK0:   req0_ready = req0_valid;
            LOCK1:   req1_ready = req1_valid;
            default: ;
        endcase

        xfer0 = req0_valid && req0_ready;
        xfer1 = req1_valid && req1_ready;

        mem_addr_d = mem_addr_q;
        last_d     = last_q;
        if (xfer0) begin
            mem_addr_d = req0_addr;
            last_d     = 1'b0;
        end else if (xfer1) begin
            mem_addr_d = req1_addr;
            last_d     = 1'b1;
        end

        // In LOCKn the owner is always ready, so dropping lock releases
        // whether or not it transfers this cycle.
        case (state_q)
            ARB: begin
                if (xfer0 && lock0)      state_d = LOCK0;
                else if (xfer1 && lock1) state_d = LOCK1;
            end
            LOCK0:   if (!lock0) state_d = ARB;
            LOCK1:   if (!lock1) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            last_q     <= 1'b1;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    rom_arb_rsp_pipe #(
        .DATA_W (DATA_W)
    ) u_rsp_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (xfer0 || xfer1),
        .issue_id    (xfer1),
        .mem_dout    (mem_dout),
        .rsp0_valid  (rsp0_valid),
        .rsp0_data   (rsp0_data),
        .rsp1_valid  (rsp1_valid),
        .rsp1_data   (rsp1_data),
        .occupied    (pipe_occupied)
    );

    assign mem_addr = mem_addr_q;
    assign busy     = (state_q != ARB) || pipe_occupied;

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, width of the character-ROM word address.
REQ-002 Parameter DATA_W, default 16, width of a packed-ASCII ROM word.
REQ-003 clk  input  1  single clock; every flop is rising-edge on clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid  input  1  requester 0 (transformer) wants a ROM read.
REQ-006 req0_addr  input  ADDR_W  requester 0 word address.
REQ-007 req0_lock  input  1  requester 0 asks to hold the grant for a burst.
REQ-008 req0_ready  output  1  requester 0 address accepted this cycle.
REQ-009 rsp0_valid  output  1  one-cycle pulse: rsp0_data holds requester 0's word.
REQ-010 rsp0_data  output  DATA_W  read data for requester 0.
REQ-011 req1_valid / req1_addr / req1_lock / req1_ready / rsp1_valid / rsp1_data: same as REQ-005..010 for requester 1 (callsign beacon).
REQ-012 mem_addr  output  ADDR_W  registered address to the combinational character ROM.
REQ-013 mem_dout  input  DATA_W  ROM data for mem_addr, valid the same cycle.
REQ-014 busy  output  1  high while any read is in flight or a lock is held.

Function
REQ-015 Handshake: transfer on reqN_valid && reqN_ready; reqN_ready depends combinationally on valid inputs and state, never both readies high in one cycle.
REQ-016 Throughput: one transfer per cycle sustained; no bubbles between back-to-back grants.
REQ-017 Latency: transfer in cycle N -> mem_addr = addr from edge ending N; mem_dout captured at edge ending N+1; rspN_valid high for exactly cycle N+2 with rspN_data.
REQ-018 Response routed to the requester that owned the transfer, tracked by a 2-stage id pipeline; rsp data of the other port holds previous value.
REQ-019 Round-robin: when both valid and unlocked, grant the requester not granted last; single valid requester always granted.
REQ-020 FSM states ARB, LOCK0, LOCK1; ARB -> LOCKn on transfer from n with reqn_lock=1; LOCKn -> ARB on transfer from n with reqn_lock=0, or cycle with reqn_valid=0 and reqn_lock=0.
REQ-021 In LOCKn only requester n may be granted; other requester's ready held 0.
REQ-022 mem_addr holds its last value when no transfer occurs.
REQ-023 Address width: addresses used unmodified, no wrap or offset applied.
REQ-024 busy = state!=ARB or either response pipeline stage occupied.

Reset
REQ-025 On rst_n low: state=ARB, last-grant=1 (requester 0 wins first tie), mem_addr=0, rsp0/1_valid=0, rsp0/1_data=0, pipeline ids cleared, busy=0.
REQ-026 Reset mid-transfer discards in-flight reads; no rsp_valid is produced for them after release.

Configuration
REQ-027 Macro ROM_ARBITER_LOCK_EN defined: lock inputs and LOCK0/LOCK1 states as specified.
REQ-028 Macro undefined: reqN_lock inputs ignored, FSM never leaves ARB, pure round-robin.

Structure
REQ-029 Package rom_arb_pkg holds ADDR_W/DATA_W defaults, state enum (ARB, LOCK0, LOCK1) and 1-bit requester-id type.
REQ-030 Sub-module rom_arb_rsp_pipe holds the 2-stage valid/id pipeline and response registers; rom_arbiter instantiates it once.

Verification
REQ-031 Only req0 valid, addr 0x05, ROM word 0x5C66 -> req0_ready=1 same cycle, rsp0_valid one cycle two cycles later with 0x5C66, rsp1_valid stays 0.
REQ-032 Both valid continuously, addrs 0x10/0x20 -> grants alternate 0,1,0,1 from reset, one response per cycle, each to correct port.
REQ-033 LOCK_EN: req0 valid+lock for 3 transfers, req1 valid throughout -> req1_ready=0 until req0 drops lock, then req1 granted next cycle.
REQ-034 No LOCK_EN: same stimulus as REQ-033 -> strict alternation, lock ignored.
REQ-035 Assert rst_n low one cycle after a transfer -> no rsp_valid ever for it, all outputs reset values, busy=0.
REQ-036 Idle 10 cycles after transfer of addr 0x2A -> mem_addr stays 0x2A, busy=0 from third cycle.
